grid_row_streamer: RTL and testbench
====================================

# grid_row_streamer

Downstream consumer of the cell matrix. On request it captures a full snapshot of the flattened ROWS×COLS life grid and streams it out one row per valid/ready beat, tagged with a frame sequence number. It sits between the free-running matrix and any display or serial host link. Snapshots requested while a frame is still streaming are dropped and counted.

## Interface
Parameters:
- ROWS, 8, grid rows; ≥2
- COLS, 8, grid columns and beat data width; ≥2

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- _rst  in  1  reset; reset is synchronous and active-high
- grid_i  in  ROWS*COLS  live matrix state; bit r*COLS+c = cell (r,c)
- snap_req  in  1  single-cycle capture request
- m_valid  out  1  beat valid
- m_ready  in  1  consumer ready
- m_data  out  COLS  row bits; bit c = cell (r,c)
- m_row  out  $clog2(ROWS)  row index of current beat
- m_last  out  1  final beat of frame
- m_trailer  out  1  beat is population trailer (tied 0 without macro)
- m_frame  out  16  sequence number of frame being streamed
- busy  out  1  frame held, not yet fully transferred
- drop_cnt  out  8  saturating count of rejected snap_req

## Operation
- States: S_IDLE, S_ROWS, S_TRAILER (trailer only with macro).
- S_IDLE: snap_req=1 → register grid_i into snapshot, row counter=0, m_frame=frame counter, frame counter+1 → S_ROWS.
- S_ROWS: m_valid=1, m_data=snapshot row m_row. On m_valid&&m_ready: if m_row<ROWS-1 increment; else go to S_TRAILER (macro) or finish.
- S_TRAILER: one beat, m_data=population count, m_row=0, m_trailer=1, m_last=1; handshake → finish.
- Finish: if snap_req asserted in the same cycle as the final handshake, accept it (new capture, row 0, no bubble); else → S_IDLE.
- snap_req in any other non-idle cycle: rejected; drop_cnt+1, saturates at 255.
- Frame counter 16-bit, first frame 0, wraps 0xFFFF→0x0000.
- m_last=1 on row ROWS-1 beat without macro; 0 there with macro.
- Held outputs (m_data, m_row, m_last, m_trailer, m_frame) stable while m_valid&&!m_ready.
- m_valid never deasserts without a handshake except via reset.

## Timing
- Reset values: m_valid 0, m_data 0, m_row 0, m_last 0, m_trailer 0, m_frame 0, busy 0, drop_cnt 0; frame counter 0, state S_IDLE.
- _rst mid-frame: beat discarded, all above values at next edge; reset dominates snap_req in the same cycle.
- snap_req at cycle T (idle) → m_valid=1, busy=1 from T+1; snapshot = grid_i sampled at edge ending T.
- m_ready held high: one row per cycle; frame occupies ROWS cycles (ROWS+1 with macro).
- Final handshake at T, no snap_req → m_valid=0, busy=0 at T+1.
- drop_cnt updates one cycle after rejected request.

## Configuration
- GRID_POPCOUNT_EN defined: population count (live cells, 0..ROWS*COLS) computed from grid_i at capture and registered with snapshot; sent as trailer beat after last row. Elaboration error if $clog2(ROWS*COLS+1) > COLS.
- Not defined: no S_TRAILER, no popcount logic, m_trailer tied 0, frame = ROWS beats.

## Structure
- Package grid_stream_pkg: ROWS/COLS defaults, state enum (S_IDLE, S_ROWS, S_TRAILER), FRAME_W=16, DROP_W=8, row index width function.
- Sub-module grid_popcount: combinational adder tree ROWS*COLS → count; instantiated only under GRID_POPCOUNT_EN.

## Test plan
- Reset, then snap_req with grid_i=0x8142_2418_1824_4281, m_ready=1 → beats rows 0..7 = 0x81,0x42,0x24,0x18,0x18,0x24,0x42,0x81 on consecutive cycles, m_frame=0, m_last on row 7 (trailer 0x10 with macro).
- m_ready toggled 1/0 per cycle → each row held stable while stalled; 16 cycles for 8 rows; no row skipped or repeated.
- snap_req 3 times mid-frame → drop_cnt=3, frame unaffected; 260 mid-frame requests → drop_cnt=255.
- snap_req coincident with final handshake → next cycle m_valid=1, m_row=0, m_frame incremented, new grid_i data.
- _rst asserted at row 4 with m_valid high → next cycle all outputs at reset values; subsequent snapshot has m_frame=0.
- Force frame counter to 0xFFFF, two snapshots → m_frame 0xFFFF then 0x0000.

Source files
------------

// File: rtl/grid_stream_pkg.sv
`default_nettype none
// ============================================================================
// grid_stream_pkg : shared types and widths for the grid row streamer
// Rev 1.0
// ============================================================================
package grid_stream_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;
  localparam int FRAME_W  = 16;
  localparam int DROP_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ROWS    = 2'd1,
    S_TRAILER = 2'd2
  } state_t;

  function automatic int row_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_popcount.sv
`default_nettype none
// ============================================================================
// grid_popcount : combinational count of set bits across the flattened grid
// Rev 1.0
// ============================================================================
module grid_popcount #(
  parameter int N = 64,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + W'(i_bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/grid_row_streamer.sv
`default_nettype none
// ============================================================================
// grid_row_streamer : snapshots the life grid and streams it one row per beat
// Optional macro GRID_POPCOUNT_EN appends a population-count trailer beat.
// Rev 1.0
// ============================================================================
module grid_row_streamer
  import grid_stream_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                    clk,
  input  logic                    _rst,
  input  logic [ROWS*COLS-1:0]    grid_i,
  input  logic                    snap_req,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [COLS-1:0]         m_data,
  output logic [$clog2(ROWS)-1:0] m_row,
  output logic                    m_last,
  output logic                    m_trailer,
  output logic [FRAME_W-1:0]      m_frame,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int RW = row_idx_w(ROWS);
  localparam logic [RW-1:0] c_LAST_ROW = RW'(ROWS - 1);

  state_t               r_state, w_state_nxt;
  logic [ROWS*COLS-1:0] r_snap;
  logic [RW-1:0]        r_row, w_row_nxt;
  logic [FRAME_W-1:0]   r_frame_cnt, r_frame;
  logic [DROP_W-1:0]    r_drop;
  logic                 w_hs, w_on_last_row, w_final, w_accept, w_reject;
  logic [COLS-1:0]      w_row_data;

`ifdef GRID_POPCOUNT_EN
  localparam int PW = $clog2(ROWS * COLS + 1);
  logic [PW-1:0] w_pop, r_pop;

  if (PW > COLS) begin : g_pop_width_chk
    $error("grid_row_streamer: population count does not fit in COLS bits");
  end

  grid_popcount #(.N(ROWS * COLS), .W(PW)) u_popcount (
    .i_bits  (grid_i),
    .o_count (w_pop)
  );

  always_ff @(posedge clk) begin
    if (_rst)          r_pop <= '0;
    else if (w_accept) r_pop <= w_pop;
  end

  assign w_final = w_hs && (r_state == S_TRAILER);
`else
  assign w_final = w_hs && w_on_last_row;
`endif

  assign w_hs          = m_valid && m_ready;
  assign w_on_last_row = (r_state == S_ROWS) && (r_row == c_LAST_ROW);
  // A request landing on the final handshake chains straight into the next frame.
  assign w_accept      = snap_req && ((r_state == S_IDLE) || w_final);
  assign w_reject      = snap_req && (r_state != S_IDLE) && !w_final;
  assign w_row_data    = r_snap[int'(r_row)*COLS +: COLS];

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ROWS;
          w_row_nxt   = '0;
        end
      end
      S_ROWS: begin
        if (w_hs) begin
          if (!w_on_last_row) begin
            w_row_nxt = r_row + RW'(1);
          end else begin
`ifdef GRID_POPCOUNT_EN
            w_state_nxt = S_TRAILER;
`else
            w_state_nxt = w_accept ? S_ROWS : S_IDLE;
`endif
            w_row_nxt   = '0;
          end
        end
      end
`ifdef GRID_POPCOUNT_EN
      S_TRAILER: begin
        if (w_hs) begin
          w_state_nxt = w_accept ? S_ROWS : S_IDLE;
          w_row_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_row_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    m_data    = '0;
    m_last    = 1'b0;
    m_trailer = 1'b0;
    if (r_state == S_ROWS) begin
      m_data = w_row_data;
`ifndef GRID_POPCOUNT_EN
      m_last = w_on_last_row;
`endif
    end
`ifdef GRID_POPCOUNT_EN
    if (r_state == S_TRAILER) begin
      m_data    = COLS'(r_pop);
      m_last    = 1'b1;
      m_trailer = 1'b1;
    end
`endif
  end

  assign m_valid  = (r_state != S_IDLE);
  assign busy     = m_valid;
  assign m_row    = r_row;
  assign m_frame  = r_frame;
  assign drop_cnt = r_drop;

  always_ff @(posedge clk) begin
    if (_rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_snap      <= '0;
      r_frame_cnt <= '0;
      r_frame     <= '0;
      r_drop      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      if (w_accept) begin
        r_snap      <= grid_i;
        r_frame     <= r_frame_cnt;
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
      if (w_reject && (r_drop != '1)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_row_streamer.sv
`default_nettype none
// ============================================================================
// tb_grid_row_streamer : scoreboard bench for grid_row_streamer
// Rev 1.0
// ============================================================================
module tb_grid_row_streamer;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            snap_req = 1'b0;
  logic            m_ready = 1'b0;
  logic [N-1:0]    grid_i = '0;
  logic            m_valid, m_last, m_trailer, busy;
  logic [COLS-1:0] m_data;
  logic [RW-1:0]   m_row;
  logic [15:0]     m_frame;
  logic [7:0]      drop_cnt;

  grid_row_streamer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    ._rst      (rst),
    .grid_i    (grid_i),
    .snap_req  (snap_req),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_last    (m_last),
    .m_trailer (m_trailer),
    .m_frame   (m_frame),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [COLS-1:0] data;
    logic [RW-1:0]   row;
    logic            last;
    logic            trailer;
    logic [15:0]     frame;
  } beat_t;

  beat_t       q[$];
  logic [15:0] exp_frame_cnt = '0;
  int          exp_drop = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] rnd_grid();
    return {$urandom, $urandom};
  endfunction

  task automatic push_frame(input logic [N-1:0] g);
    beat_t b;
    for (int r = 0; r < ROWS; r++) begin
      b.data    = g[r*COLS +: COLS];
      b.row     = RW'(r);
`ifdef GRID_POPCOUNT_EN
      b.last    = 1'b0;
`else
      b.last    = (r == ROWS - 1);
`endif
      b.trailer = 1'b0;
      b.frame   = exp_frame_cnt;
      q.push_back(b);
    end
`ifdef GRID_POPCOUNT_EN
    b.data    = COLS'($countones(g));
    b.row     = '0;
    b.last    = 1'b1;
    b.trailer = 1'b1;
    b.frame   = exp_frame_cnt;
    q.push_back(b);
`endif
    exp_frame_cnt = exp_frame_cnt + 16'd1;
  endtask

  // One clock cycle: drive at negedge, compare outputs, advance model, return at next negedge.
  task automatic step(input logic rs, input logic rq, input logic rdy, input logic [N-1:0] g);
    bit was_idle, hs, final_hs;
    rst = rs; snap_req = rq; m_ready = rdy; grid_i = g;
    #1;
    check("valid", m_valid, q.size() != 0);
    check("busy", busy, q.size() != 0);
    check("drop_cnt", drop_cnt, exp_drop);
    if (q.size() != 0) begin
      check("data", m_data, q[0].data);
      check("row", m_row, q[0].row);
      check("last", m_last, q[0].last);
      check("trailer", m_trailer, q[0].trailer);
      check("frame", m_frame, q[0].frame);
    end
    was_idle = (q.size() == 0);
    hs       = !was_idle && rdy;
    if (rs) begin
      q.delete();
      exp_frame_cnt = '0;
      exp_drop      = 0;
    end else begin
      if (hs) void'(q.pop_front());
      final_hs = hs && (q.size() == 0);
      if (rq && (was_idle || final_hs)) push_frame(g);
      else if (rq && exp_drop < 255) exp_drop++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, 1'b0, 1'b1, rnd_grid());
    step(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_valid"}, m_valid, 0);
    check({t, "_data"}, m_data, 0);
    check({t, "_row"}, m_row, 0);
    check({t, "_last"}, m_last, 0);
    check({t, "_trailer"}, m_trailer, 0);
    check({t, "_frame"}, m_frame, 0);
    check({t, "_busy"}, busy, 0);
    check({t, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] prev_frame;
    @(negedge clk);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    check_reset_outputs("rst0");

    // Known symmetric pattern, ready held high
    step(1'b0, 1'b1, 1'b1, 64'h8142_2418_1824_4281);
    check("pat_row0", m_data, 8'h81);
    repeat (ROWS + 2) step(1'b0, 1'b0, 1'b1, rnd_grid());

    // Ready toggling every cycle
    step(1'b0, 1'b1, 1'b1, rnd_grid());
    for (int i = 0; i < 2 * ROWS + 4; i++) step(1'b0, 1'b0, (i % 2) == 1, rnd_grid());
    drain();

    // Three rejected requests mid-frame
    step(1'b0, 1'b1, 1'b0, rnd_grid());
    repeat (3) step(1'b0, 1'b1, 1'b0, rnd_grid());
    check("drop_after3", drop_cnt, 3);
    drain();

    // Saturation of the drop counter
    step(1'b0, 1'b1, 1'b0, rnd_grid());
    repeat (260) step(1'b0, 1'b1, 1'b0, rnd_grid());
    check("drop_sat", drop_cnt, 255);
    drain();

    // Request coincident with final handshake chains the next frame
    step(1'b0, 1'b1, 1'b1, rnd_grid());
    prev_frame = m_frame;
    for (int i = 0; i < 50 && q.size() > 1; i++) step(1'b0, 1'b0, 1'b1, rnd_grid());
    step(1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    check("b2b_valid", m_valid, 1);
    check("b2b_row", m_row, 0);
    check("b2b_frame", m_frame, prev_frame + 16'd1);
    check("b2b_data", m_data, 8'hEF);
    drain();

    // Reset mid-frame at row 4, with a coincident request
    step(1'b0, 1'b1, 1'b1, rnd_grid());
    for (int i = 0; i < 20 && q.size() != 0 && q[0].row != RW'(4); i++)
      step(1'b0, 1'b0, 1'b1, rnd_grid());
    check("pre_rst_row", m_row, 4);
    step(1'b1, 1'b1, 1'b1, rnd_grid());
    check_reset_outputs("rst_mid");
    step(1'b0, 1'b1, 1'b1, rnd_grid());
    check("post_rst_frame", m_frame, 0);
    drain();

    // Frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    exp_frame_cnt = 16'hFFFF;
    step(1'b0, 1'b1, 1'b1, rnd_grid());
    check("wrap_first", m_frame, 16'hFFFF);
    drain();
    step(1'b0, 1'b1, 1'b1, rnd_grid());
    check("wrap_second", m_frame, 16'h0000);
    drain();

    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
